// File: rtl/soc_boot_ctrl_if.sv
// soc_boot_ctrl_if: raw button/switch inputs and sequenced reset/select outputs of the boot controller
interface soc_boot_ctrl_if;
  logic       btn_rst_n_i;
  logic       chip_sel_i;
  logic       sys_rst_n_o;
  logic       core0_rst_n_o;
  logic       core1_rst_n_o;
  logic       chip_sel_o;
  logic       busy_o;
  logic [7:0] boot_cnt_o;
  modport master (
    output btn_rst_n_i, chip_sel_i,
    input  sys_rst_n_o, core0_rst_n_o, core1_rst_n_o, chip_sel_o, busy_o, boot_cnt_o
  );
  modport slave (
    input  btn_rst_n_i, chip_sel_i,
    output sys_rst_n_o, core0_rst_n_o, core1_rst_n_o, chip_sel_o, busy_o, boot_cnt_o
  );
endinterface

// File: rtl/soc_boot_ctrl.sv
// soc_boot_ctrl: debounced reset/core-select sequencer producing glitch-free system and per-core resets
module soc_boot_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int HOLD_CYCLES     = 16,
  parameter int CNT_W           = 16
) (
  input logic            clk,
  input logic            rst,
  soc_boot_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_HOLD, S_RUN, S_SWITCH} state_t;
  localparam logic [1:0] RST_VAL = 2'b01;
  logic [1:0] raw, deb;
  state_t state, state_n;
  logic [CNT_W-1:0] hold, hold_n;
  logic sel_n;
  assign raw = {bus.chip_sel_i, bus.btn_rst_n_i};
  for (genvar i = 0; i < 2; i++) begin : g_in
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0] cnt;
    logic d;
    assign deb[i] = d;
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        sync_q <= {SYNC_STAGES{RST_VAL[i]}};
        cnt    <= '0;
        d      <= RST_VAL[i];
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw[i]};
        if (sync_q[SYNC_STAGES-1] == d) cnt <= '0;
        else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          d   <= sync_q[SYNC_STAGES-1];
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      end
  end
  always_comb begin
    state_n = state;
    hold_n  = hold;
    sel_n   = bus.chip_sel_o;
    case (state)
      S_HOLD: begin
        sel_n  = deb[1];
        hold_n = deb[0] ? hold + 1'b1 : '0;
        if (deb[0] && hold == CNT_W'(HOLD_CYCLES - 1)) begin
          state_n = S_RUN;
          hold_n  = '0;
        end
      end
      S_RUN: begin
        if (!deb[0]) begin
          state_n = S_HOLD;
          hold_n  = '0;
        end else if (deb[1] != bus.chip_sel_o) begin
          state_n = S_SWITCH;
          hold_n  = '0;
        end
      end
      S_SWITCH: begin
        sel_n  = (hold == '0) ? deb[1] : bus.chip_sel_o;
        hold_n = hold + 1'b1;
        if (!deb[0]) begin
          state_n = S_HOLD;
          hold_n  = '0;
        end else if (hold == CNT_W'(HOLD_CYCLES - 1)) begin
          state_n = S_RUN;
          hold_n  = '0;
        end
      end
      default: begin
        state_n = S_HOLD;
        hold_n  = '0;
      end
    endcase
  end
  // outputs are registered from the next state so every reset line is a bare flop
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state             <= S_HOLD;
      hold              <= '0;
      bus.chip_sel_o    <= 1'b0;
      bus.sys_rst_n_o   <= 1'b0;
      bus.core0_rst_n_o <= 1'b0;
      bus.core1_rst_n_o <= 1'b0;
      bus.busy_o        <= 1'b1;
      bus.boot_cnt_o    <= '0;
    end else begin
      state             <= state_n;
      hold              <= hold_n;
      bus.chip_sel_o    <= sel_n;
      bus.sys_rst_n_o   <= state_n != S_HOLD;
      bus.core0_rst_n_o <= state_n == S_RUN && !sel_n;
      bus.core1_rst_n_o <= state_n == S_RUN && sel_n;
      bus.busy_o        <= state_n != S_RUN;
      if (state != S_RUN && state_n == S_RUN) bus.boot_cnt_o <= bus.boot_cnt_o + 1'b1;
    end
endmodule

// File: tb/tb_soc_boot_ctrl.sv
// tb_soc_boot_ctrl: directed boot/switch scenarios plus random input churn checked against a behavioural model
module tb_soc_boot_ctrl;
  localparam int SS = 2, DC = 4, HC = 8;
  logic clk = 1'b0, rst = 1'b0;
  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;
  always #5 clk = ~clk;
  soc_boot_ctrl_if bus();
  soc_boot_ctrl #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .HOLD_CYCLES(HC), .CNT_W(16))
    dut (.clk(clk), .rst(rst), .bus(bus));
  bit q_b[$], q_s[$];
  bit d_b, d_s, m_sel;
  int r_b, r_s, mode, t, boot;
  task automatic check(string tag, logic [12:0] got, logic [12:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [12:0] outs();
    return {bus.sys_rst_n_o, bus.core0_rst_n_o, bus.core1_rst_n_o, bus.chip_sel_o, bus.busy_o, bus.boot_cnt_o};
  endfunction
  function automatic logic [12:0] m_outs();
    return {mode != 0, mode == 1 && !m_sel, mode == 1 && m_sel, m_sel, mode != 1, 8'(boot)};
  endfunction
  task automatic m_reset();
    q_b = {};
    q_s = {};
    repeat (SS) begin
      q_b.push_back(1'b1);
      q_s.push_back(1'b0);
    end
    d_b = 1'b1; d_s = 1'b0; r_b = 0; r_s = 0;
    mode = 0; t = 0; m_sel = 1'b0; boot = 0;
  endtask
  // mode: 0 hold, 1 run, 2 switch; t counts cycles spent in hold (button released) or switch
  task automatic m_step();
    bit sb, ss, pb, ps;
    pb = d_b; ps = d_s;
    sb = q_b.pop_front(); ss = q_s.pop_front();
    q_b.push_back(bus.btn_rst_n_i); q_s.push_back(bus.chip_sel_i);
    r_b = (sb != d_b) ? r_b + 1 : 0;
    if (r_b == DC) begin d_b = sb; r_b = 0; end
    r_s = (ss != d_s) ? r_s + 1 : 0;
    if (r_s == DC) begin d_s = ss; r_s = 0; end
    if (mode == 0) begin
      m_sel = ps;
      t = pb ? t + 1 : 0;
      if (t == HC) begin mode = 1; t = 0; boot = (boot + 1) % 256; end
    end else if (mode == 1) begin
      if (!pb) begin mode = 0; t = 0; end
      else if (ps != m_sel) begin mode = 2; t = 0; end
    end else begin
      if (t == 0) m_sel = ps;
      t++;
      if (!pb) begin mode = 0; t = 0; end
      else if (t == HC) begin mode = 1; t = 0; boot = (boot + 1) % 256; end
    end
  endtask
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) m_reset(); else m_step();
  end
  initial forever begin
    @(negedge clk);
    if (chk_en) check("model", outs(), m_outs());
  end
  task automatic wait_n(int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    m_reset();
    bus.btn_rst_n_i = 1'b1;
    bus.chip_sel_i  = 1'b0;
    chk_en = 1'b1;
    wait_n(3);
    check("reset", outs(), 13'b0_0_0_0_1_00000000);
    rst = 1'b1;
    wait_n(7);
    check("s1_pre", 13'(bus.sys_rst_n_o), 13'd0);
    wait_n(1);
    check("s1_boot", outs(), {5'b11000, 8'd1});
    bus.chip_sel_i = 1'b1;
    wait_n(6);
    check("s2_pre", 13'(bus.core0_rst_n_o), 13'd1);
    wait_n(1);
    check("s2_fall", outs(), {5'b10001, 8'd1});
    wait_n(1);
    check("s2_flip", 13'(bus.chip_sel_o), 13'd1);
    wait_n(6);
    check("s2_wait", 13'(bus.core1_rst_n_o), 13'd0);
    wait_n(1);
    check("s2_run", outs(), {5'b10110, 8'd2});
    bus.btn_rst_n_i = 1'b0;
    wait_n(3);
    bus.btn_rst_n_i = 1'b1;
    wait_n(12);
    check("s3_glitch", outs(), {5'b10110, 8'd2});
    bus.btn_rst_n_i = 1'b0;
    wait_n(5);
    bus.btn_rst_n_i = 1'b1;
    wait_n(1);
    check("s3_pre", 13'(bus.sys_rst_n_o), 13'd1);
    wait_n(1);
    check("s3_low", outs(), {5'b00011, 8'd2});
    wait_n(11);
    check("s3_wait", 13'(bus.sys_rst_n_o), 13'd0);
    wait_n(1);
    check("s3_run", outs(), {5'b10110, 8'd3});
    bus.chip_sel_i = 1'b0;
    wait_n(7);
    check("s4_sw", outs(), {5'b10011, 8'd3});
    bus.btn_rst_n_i = 1'b0;
    wait_n(40);
    check("s4_hold", outs(), {5'b00001, 8'd3});
    bus.btn_rst_n_i = 1'b1;
    wait_n(30);
    check("s4_run", outs(), {5'b11000, 8'd4});
    bus.chip_sel_i = 1'b1;
    wait_n(10);
    check("s5_mid", 13'(bus.busy_o), 13'd1);
    rst = 1'b0;
    #1;
    check("s5_rst", outs(), 13'b0_0_0_0_1_00000000);
    wait_n(1);
    rst = 1'b1;
    wait_n(20);
    check("s5_boot", outs(), {5'b10110, 8'd1});
    for (int i = 0; i < 255; i++) begin
      bus.chip_sel_i = ~bus.chip_sel_i;
      wait_n(20);
    end
    check("s6_wrap", outs(), {5'b11000, 8'd0});
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!rst) rst = 1'b1;
      else if ($urandom_range(199) == 0) rst = 1'b0;
      if ($urandom_range(7) == 0) bus.btn_rst_n_i = ~bus.btn_rst_n_i;
      if ($urandom_range(7) == 0) bus.chip_sel_i = ~bus.chip_sel_i;
    end
    rst = 1'b1;
    bus.btn_rst_n_i = 1'b1;
    wait_n(40);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
